// File: rtl/mc_pi_engine.sv
// Monte Carlo pi-estimation core: a 32-bit Galois LFSR supplies one (x,y) point per cycle,
// and a 3-stage pipeline counts the points that fall inside the quarter circle of radius 2^COORD_W.
module mc_pi_engine #(
    parameter int COORD_W = 16,
    parameter int CNT_W   = 32
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic [31:0]      seed,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] sample_count,
    output logic [1:0]       state_dbg
);

    localparam int PW = 2 * COORD_W;
    localparam logic [31:0] POLY = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_next;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             issue;

    logic          s1_valid;
    logic [PW-1:0] xx;
    logic [PW-1:0] yy;
    logic          s2_valid;
    logic [PW:0]   sum;
    logic [PW-1:0] x_ext;
    logic [PW-1:0] y_ext;

    assign state_dbg = state;
    assign accept    = start && (state == IDLE || state == DONE);
    assign issue     = (state == RUN);
    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
    assign x_ext     = PW'(lfsr[31:32-COORD_W]);
    assign y_ext     = PW'(lfsr[COORD_W-1:0]);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            lfsr      <= 32'h0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        lfsr      <= (seed == 32'h0) ? 32'h1 : seed;
                        remaining <= n_samples;
                        if (n_samples != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    lfsr      <= lfsr_next;
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) state <= DRAIN;
                end
                DRAIN: begin
                    // Both stages empty means the last sample was counted on the previous edge.
                    if (!s1_valid && !s2_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s1_valid     <= 1'b0;
            xx           <= '0;
            yy           <= '0;
            s2_valid     <= 1'b0;
            sum          <= '0;
            hit_count    <= '0;
            sample_count <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                xx <= x_ext * x_ext;
                yy <= y_ext * y_ext;
            end
            s2_valid <= s1_valid;
            if (s1_valid) sum <= {1'b0, xx} + {1'b0, yy};
            // Accept only happens with the pipeline empty, so clearing cannot drop a sample.
            if (accept) begin
                hit_count    <= '0;
                sample_count <= '0;
            end else if (s2_valid) begin
                sample_count <= sample_count + 1'b1;
                hit_count    <= hit_count + {{(CNT_W-1){1'b0}}, ~sum[PW]};
            end
        end
    end

endmodule

// File: tb/tb_mc_pi_engine.sv
// Directed bench for mc_pi_engine: reset, boundary points, start guard and an LFSR-model run.
module tb_mc_pi_engine;

    logic        ACLK;
    logic        ARESETN;
    logic        start;
    logic [31:0] n_samples;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic [31:0] hit_count;
    logic [31:0] sample_count;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    mc_pi_engine #(.COORD_W(16), .CNT_W(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .n_samples(n_samples), .seed(seed),
        .busy(busy), .done(done), .hit_count(hit_count), .sample_count(sample_count),
        .state_dbg(state_dbg)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // The edge inside this task is E0; stray input values afterwards must not matter.
    task automatic do_start(input logic [31:0] n, input logic [31:0] s);
        start = 1'b1;
        n_samples = n;
        seed = s;
        step();
        start = 1'b0;
        n_samples = $urandom;
        seed = $urandom;
    endtask

    task automatic wait_done(input int max_edges, output int edges);
        edges = 0;
        while (!done && edges < max_edges) begin
            step();
            edges++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_hit"}, 64'(hit_count), 64'd0);
        chk({tag, "_smp"}, 64'(sample_count), 64'd0);
        chk({tag, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    function automatic int unsigned model_hits(input int unsigned n, input logic [31:0] s);
        logic [31:0] l;
        logic [63:0] x;
        logic [63:0] y;
        int unsigned h;
        l = (s == 32'h0) ? 32'h1 : s;
        h = 0;
        for (int unsigned i = 0; i < n; i++) begin
            x = 64'(l[31:16]);
            y = 64'(l[15:0]);
            if (x * x + y * y < 64'h1_0000_0000) h++;
            l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
        end
        return h;
    endfunction

    initial begin
        int edges;
        int unsigned exp_h;
        ARESETN = 1'b0;
        start = 1'b0;
        n_samples = '0;
        seed = '0;
        repeat (3) step();
        chk_all_zero("por");
        ARESETN = 1'b1;
        step();

        // Reset asserted on a clock edge mid-run.
        do_start(32'd1000, 32'hACE1);
        repeat (20) step();
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_smp20", 64'(sample_count), 64'd18);
        @(posedge ACLK);
        ARESETN = 1'b0;
        #1;
        chk_all_zero("rst_edge");
        step();
        ARESETN = 1'b1;
        repeat (5) step();
        chk("no_resume_busy", 64'(busy), 64'd0);
        chk("no_resume_smp", 64'(sample_count), 64'd0);

        // Reset asserted between edges mid-run.
        do_start(32'd1000, 32'hACE1);
        repeat (10) step();
        #2;
        ARESETN = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        step();
        ARESETN = 1'b1;
        step();

        // n=1, x=y=1: done exactly at E4.
        do_start(32'd1, 32'h00010001);
        chk("n1_busy_e0", 64'(busy), 64'd1);
        wait_done(30, edges);
        chk("n1_done_edge", 64'(edges), 64'd4);
        chk("n1_busy_end", 64'(busy), 64'd0);
        chk("n1_hit", 64'(hit_count), 64'd1);
        chk("n1_smp", 64'(sample_count), 64'd1);

        // n=0: done right after accept, counters cleared.
        do_start(32'd0, 32'd5);
        chk("n0_done", 64'(done), 64'd1);
        chk("n0_busy", 64'(busy), 64'd0);
        chk("n0_hit", 64'(hit_count), 64'd0);
        chk("n0_smp", 64'(sample_count), 64'd0);
        chk("n0_state", 64'(state_dbg), 64'd3);

        // Largest coordinates: sum well above 2^32.
        do_start(32'd1, 32'hFFFFFFFF);
        chk("ff_done_cleared", 64'(done), 64'd0);
        wait_done(30, edges);
        chk("ff_done_edge", 64'(edges), 64'd4);
        chk("ff_hit", 64'(hit_count), 64'd0);
        chk("ff_smp", 64'(sample_count), 64'd1);

        // x=0xFFFF, y=0: just inside the circle.
        do_start(32'd1, 32'hFFFF0000);
        wait_done(30, edges);
        chk("edge_hit", 64'(hit_count), 64'd1);
        chk("edge_smp", 64'(sample_count), 64'd1);

        // seed 0 becomes 1, i.e. x=0, y=1.
        do_start(32'd1, 32'h0);
        wait_done(30, edges);
        chk("seed0_hit", 64'(hit_count), 64'd1);
        chk("seed0_smp", 64'(sample_count), 64'd1);

        // A start pulse during a run is ignored.
        do_start(32'd50, 32'h12345678);
        repeat (9) step();
        do_start(32'd7, 32'd3);
        wait_done(100, edges);
        chk("guard_done_edge", 64'(edges + 10), 64'd53);
        chk("guard_smp", 64'(sample_count), 64'd50);
        exp_h = model_hits(50, 32'h12345678);
        chk("guard_hit", 64'(hit_count), 64'(exp_h));

        // Longer run against the LFSR model.
        do_start(32'd3000, 32'hACE1);
        wait_done(3100, edges);
        chk("stat_done_edge", 64'(edges), 64'd3003);
        chk("stat_smp", 64'(sample_count), 64'd3000);
        exp_h = model_hits(3000, 32'hACE1);
        chk("stat_hit", 64'(hit_count), 64'(exp_h));
        chk("stat_pi_range", 64'((hit_count * 4 >= 32'd9000) && (hit_count * 4 <= 32'd9900)), 64'd1);
        repeat (3) step();
        chk("stat_hold_hit", 64'(hit_count), 64'(exp_h));
        chk("stat_hold_done", 64'(done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
